// File: rtl/maq_pkg.sv
// Shared types and constants for the hour counter and its display converter.
package maq_pkg;

  typedef logic [3:0] bcd_t;

  localparam int BCD_MAX   = 9;
  localparam int H_NOON    = 12;
  localparam int H_DIA_MAX = 23;
  localparam int H_W       = 6;

  // Tens digit of a binary value in 0..39.
  function automatic logic [1:0] bcd_tens(input logic [H_W-1:0] v);
    logic [1:0] t;
    if (v >= 6'd30) begin
      t = 2'd3;
    end else if (v >= 6'd20) begin
      t = 2'd2;
    end else if (v >= 6'd10) begin
      t = 2'd1;
    end else begin
      t = 2'd0;
    end
    return t;
  endfunction

endpackage

// File: rtl/maq_h_conv.sv
// Combinational binary hour -> BCD display converter with optional 12 h mapping and PM flag.
module maq_h_conv
  import maq_pkg::*;
#(
  parameter int MAX_H = 23,
  parameter int MSD_W = 2
) (
  input  logic [H_W-1:0]   hour_i,
  input  logic             modo12_i,
  output bcd_t             lsd_o,
  output logic [MSD_W-1:0] msd_o,
  output logic             pm_o
);

  logic [H_W-1:0] disp_s;
  logic [1:0]     tens_s;
  logic           pm_s;

  // 12 h mapping applies only to a day-length counter
  always_comb begin
    disp_s = hour_i;
    pm_s   = 1'b0;
    if (modo12_i && (MAX_H == H_DIA_MAX)) begin
      pm_s = (hour_i >= H_W'(H_NOON));
      if (hour_i == 6'd0) begin
        disp_s = H_W'(H_NOON);
      end else if (hour_i > H_W'(H_NOON)) begin
        disp_s = hour_i - H_W'(H_NOON);
      end else begin
        disp_s = hour_i;
      end
    end else begin
      disp_s = hour_i;
      pm_s   = 1'b0;
    end
  end

  assign tens_s = bcd_tens(disp_s);
  assign lsd_o  = 4'(disp_s - (H_W'(tens_s) * 6'd10));
  assign msd_o  = MSD_W'(tens_s);
  assign pm_o   = pm_s;

endmodule

// File: rtl/maq_h_param.sv
// Parametrised hour counter with BCD display, 12/24 h mode, count-down, checked load and day carry.
// Optional alarm comparator enabled by defining MAQHP_ALARM_EN.
module maq_h_param
  import maq_pkg::*;
#(
  parameter int MAX_H = 23,
  parameter int MSD_W = 2
) (
  input  logic             maqhp_clock,
  input  logic             maqhp_reset,
  input  logic             maqhp_enable,
  input  logic             maqhp_incremento,
  input  logic             maqhp_decremento,
  input  logic             maqhp_modo12,
  input  logic             maqhp_load,
  input  logic [3:0]       maqhp_load_Lsd,
  input  logic [MSD_W-1:0] maqhp_load_Msd,
`ifdef MAQHP_ALARM_EN
  input  logic [3:0]       maqhp_alarm_Lsd,
  input  logic [MSD_W-1:0] maqhp_alarm_Msd,
  input  logic             maqhp_alarm_on,
`endif
  output logic [3:0]       maqhp_Lsd,
  output logic [MSD_W-1:0] maqhp_Msd,
  output logic             maqhp_pm,
  output logic             maqhp_carry,
  output logic             maqhp_erro,
  output logic             maqhp_alarme
);

  localparam logic [H_W-1:0] H_MAX = H_W'(MAX_H);

  logic [H_W-1:0] h_q, h_d;
  logic           carry_q, carry_d;
  logic           erro_q, erro_d;
  logic           alarme_q, alarme_d;
  logic [7:0]     load_val_s;
  logic           load_ok_s;

  assign load_val_s = (8'(maqhp_load_Msd) * 8'd10) + 8'(maqhp_load_Lsd);
  assign load_ok_s  = (maqhp_load_Lsd <= 4'(BCD_MAX)) && (load_val_s <= 8'(MAX_H));

  // Next hour and pulse generation, load first then the tick decode
  always_comb begin
    h_d     = h_q;
    carry_d = 1'b0;
    erro_d  = 1'b0;
    if (maqhp_load) begin
      if (load_ok_s) begin
        h_d = H_W'(load_val_s);
      end else begin
        erro_d = 1'b1;
      end
    end else if (maqhp_enable && maqhp_incremento && maqhp_decremento) begin
      h_d = h_q;
    end else if (maqhp_enable && maqhp_incremento) begin
      if (h_q == H_MAX) begin
        h_d     = 6'd0;
        carry_d = 1'b1;
      end else begin
        h_d = h_q + 6'd1;
      end
    end else if (maqhp_enable && maqhp_decremento) begin
      if (h_q == 6'd0) begin
        h_d = H_MAX;
      end else begin
        h_d = h_q - 6'd1;
      end
    end else begin
      h_d = h_q;
    end
  end

`ifdef MAQHP_ALARM_EN
  logic [7:0] alarm_val_s;
  logic       alarm_ok_s;
  logic       inc_tick_s;

  assign alarm_val_s = (8'(maqhp_alarm_Msd) * 8'd10) + 8'(maqhp_alarm_Lsd);
  assign alarm_ok_s  = (maqhp_alarm_Lsd <= 4'(BCD_MAX)) && (alarm_val_s <= 8'(MAX_H));
  assign inc_tick_s  = !maqhp_load && maqhp_enable && maqhp_incremento && !maqhp_decremento;
  assign alarme_d    = inc_tick_s && maqhp_alarm_on && alarm_ok_s && (8'(h_d) == alarm_val_s);
`else
  assign alarme_d    = 1'b0;
`endif

  // Hour register and one-cycle pulse registers
  always_ff @(posedge maqhp_clock or negedge maqhp_reset) begin
    if (!maqhp_reset) begin
      h_q      <= 6'd0;
      carry_q  <= 1'b0;
      erro_q   <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      carry_q  <= carry_d;
      erro_q   <= erro_d;
      alarme_q <= alarme_d;
    end
  end

  maq_h_conv #(
    .MAX_H (MAX_H),
    .MSD_W (MSD_W)
  ) u_conv (
    .hour_i   (h_q),
    .modo12_i (maqhp_modo12),
    .lsd_o    (maqhp_Lsd),
    .msd_o    (maqhp_Msd),
    .pm_o     (maqhp_pm)
  );

  assign maqhp_carry  = carry_q;
  assign maqhp_erro   = erro_q;
  assign maqhp_alarme = alarme_q;

endmodule

// File: tb/tb_maq_h_param.sv
// Directed bench for maq_h_param with hand-computed expected display values.
module tb_maq_h_param;

  logic       clk = 1'b0;
  logic       rst_n, en, inc, dec, modo12, load;
  logic [3:0] ld_lsd;
  logic [1:0] ld_msd;
  logic [3:0] lsd;
  logic [1:0] msd;
  logic       pm, carry, erro, alarme;
`ifdef MAQHP_ALARM_EN
  logic [3:0] al_lsd;
  logic [1:0] al_msd;
  logic       al_on;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  maq_h_param dut (
    .maqhp_clock      (clk),
    .maqhp_reset      (rst_n),
    .maqhp_enable     (en),
    .maqhp_incremento (inc),
    .maqhp_decremento (dec),
    .maqhp_modo12     (modo12),
    .maqhp_load       (load),
    .maqhp_load_Lsd   (ld_lsd),
    .maqhp_load_Msd   (ld_msd),
`ifdef MAQHP_ALARM_EN
    .maqhp_alarm_Lsd  (al_lsd),
    .maqhp_alarm_Msd  (al_msd),
    .maqhp_alarm_on   (al_on),
`endif
    .maqhp_Lsd        (lsd),
    .maqhp_Msd        (msd),
    .maqhp_pm         (pm),
    .maqhp_carry      (carry),
    .maqhp_erro       (erro),
    .maqhp_alarme     (alarme)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int e_msd, input int e_lsd, input int e_pm);
    check_val({tag, ".msd"}, 32'(msd), 32'(e_msd));
    check_val({tag, ".lsd"}, 32'(lsd), 32'(e_lsd));
    check_val({tag, ".pm"},  32'(pm),  32'(e_pm));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
`ifndef MAQHP_ALARM_EN
    check_val("alarme_off", 32'(alarme), 32'd0);
`endif
  endtask

  task automatic idle();
    load = 1'b0; inc = 1'b0; dec = 1'b0; en = 1'b1;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [3:0] l);
    load = 1'b1; ld_msd = m; ld_lsd = l;
    tick();
    load = 1'b0;
  endtask

  task automatic do_inc();
    inc = 1'b1;
    tick();
    inc = 1'b0;
  endtask

  task automatic do_dec();
    dec = 1'b1;
    tick();
    dec = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; modo12 = 1'b0; ld_msd = 2'd0; ld_lsd = 4'd0;
    idle();
`ifdef MAQHP_ALARM_EN
    al_lsd = 4'd7; al_msd = 2'd0; al_on = 1'b0;
`endif
    #1;
    check_disp("rst0", 0, 0, 0);
    check_val("rst0.carry", 32'(carry), 32'd0);
    check_val("rst0.erro", 32'(erro), 32'd0);
    #1 rst_n = 1'b1;

    // asynchronous reset mid-count at 17, checked before the next edge
    do_load(2'd1, 4'd7);
    check_disp("ld17", 1, 7, 0);
    #2 rst_n = 1'b0;
    #1;
    check_disp("arst", 0, 0, 0);
    check_val("arst.carry", 32'(carry), 32'd0);
    load = 1'b1; ld_msd = 2'd1; ld_lsd = 4'd5;
    tick();
    check_disp("rst_vs_load", 0, 0, 0);
    load = 1'b0;
    #2 rst_n = 1'b1;

    // wrap 23 -> 0 with one-cycle carry
    do_load(2'd2, 4'd3);
    check_disp("ld23", 2, 3, 0);
    check_val("ld23.carry", 32'(carry), 32'd0);
    do_inc();
    check_disp("wrap", 0, 0, 0);
    check_val("wrap.carry", 32'(carry), 32'd1);
    do_inc();
    check_disp("inc01", 0, 1, 0);
    check_val("inc01.carry", 32'(carry), 32'd0);

    // decrement underflow and rejected loads
    do_load(2'd0, 4'd0);
    do_dec();
    check_disp("dec_wrap", 2, 3, 0);
    check_val("dec_wrap.carry", 32'(carry), 32'd0);
    do_load(2'd2, 4'd4);
    check_val("ld24.erro", 32'(erro), 32'd1);
    check_disp("ld24", 2, 3, 0);
    tick();
    check_val("erro_clr", 32'(erro), 32'd0);
    do_load(2'd0, 4'hA);
    check_val("ldA.erro", 32'(erro), 32'd1);
    check_disp("ldA", 2, 3, 0);

    // 12 h display mapping
    modo12 = 1'b1;
    do_load(2'd0, 4'd0);
    check_disp("m12_00", 1, 2, 0);
    do_load(2'd1, 4'd2);
    check_disp("m12_12", 1, 2, 1);
    do_load(2'd1, 4'd3);
    check_disp("m12_13", 0, 1, 1);
    modo12 = 1'b0;
    #1;
    check_disp("m24_13", 1, 3, 0);
    modo12 = 1'b1;
    do_load(2'd2, 4'd3);
    check_disp("m12_23", 1, 1, 1);
    modo12 = 1'b0;

    // priority: load over ticks, inc+dec holds, enable gates ticks
    load = 1'b1; inc = 1'b1; dec = 1'b1; ld_msd = 2'd0; ld_lsd = 4'd5;
    tick();
    idle();
    check_disp("prio_load", 0, 5, 0);
    inc = 1'b1; dec = 1'b1;
    tick();
    idle();
    check_disp("inc_dec_hold", 0, 5, 0);
    en = 1'b0;
    do_inc();
    en = 1'b1;
    check_disp("en_low_hold", 0, 5, 0);
    do_inc();
    check_disp("inc06", 0, 6, 0);
    do_dec();
    check_disp("dec05", 0, 5, 0);

`ifdef MAQHP_ALARM_EN
    al_on = 1'b1;
    do_load(2'd0, 4'd6);
    check_val("al_pre", 32'(alarme), 32'd0);
    do_inc();
    check_val("al_hit", 32'(alarme), 32'd1);
    check_disp("al_07", 0, 7, 0);
    tick();
    check_val("al_once", 32'(alarme), 32'd0);
    do_load(2'd0, 4'd7);
    check_val("al_load", 32'(alarme), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
